// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/condition/handshake inputs and all datapath strobes.
// master = control unit side, slave = datapath side.
interface control_unit_if;
  logic [31:0] IR;
  logic        Access;
  logic        MemReady;

  logic        RegDst;
  logic        RegIn;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        ALUFunc;
  logic        IorD;
  logic        PCWrite;
  logic        IRWrite;
  logic        ZWrite;
  logic        NWrite;
  logic        VWrite;
  logic        CWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  ALUSrcB;
  logic [1:0]  MemtoReg;

  modport master (
    input  IR, Access, MemReady,
    output RegDst, RegIn, RegWrite, ALUSrcA, ALUFunc, IorD, PCWrite, IRWrite,
           ZWrite, NWrite, VWrite, CWrite, MemRead, MemWrite, ALUSrcB, MemtoReg
  );

  modport slave (
    output IR, Access, MemReady,
    input  RegDst, RegIn, RegWrite, ALUSrcA, ALUFunc, IorD, PCWrite, IRWrite,
           ZWrite, NWrite, VWrite, CWrite, MemRead, MemWrite, ALUSrcB, MemtoReg
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM for the 32-bit conditional-execution datapath,
// with halt status and a retired-instruction counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | read IR at PC, PC += 1 when memory completes
// S_DECODE | evaluate Access; squash or dispatch on instruction class
// S_EXEC   | data-processing op, optional flag update (1 cycle)
// S_MEM    | load/store at D1 + sext imm12, held until MemReady
// S_BRANCH | PC <= PC + sext imm26, optional link into R15 (1 cycle)
// S_HALT   | stopped; only rst leaves
module control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  control_unit_if.master   dp_if,
  output logic             Halted,
  output logic [CNT_W-1:0] RetiredCnt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_BRANCH,
    S_HALT
  } state_e;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_in;
    logic       reg_write;
    logic       alu_src_a;
    logic       alu_func;
    logic       iord;
    logic       pc_write;
    logic       ir_write;
    logic       z_write;
    logic       n_write;
    logic       v_write;
    logic       c_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_src_b;
    logic [1:0] mem_to_reg;
  } ctl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t             ctl, ctl_out;
  logic             halted_int;
  logic             retire;

  logic [1:0] ir_class;
  logic       ir_ibit;
  logic       ir_sbit;
  logic       ir_load;

  assign ir_class = dp_if.IR[29:28];
  assign ir_ibit  = dp_if.IR[26];
  assign ir_sbit  = dp_if.IR[23];
  assign ir_load  = dp_if.IR[20];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctl        = '0;
    halted_int = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'd2;
        ctl.ir_write  = dp_if.MemReady;
        ctl.pc_write  = dp_if.MemReady;
        if (dp_if.MemReady) state_d = S_DECODE;
      end

      S_DECODE: begin
        if (!dp_if.Access) begin
          // Squashed instructions still count as retired.
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          case (ir_class)
            2'b00:   state_d = S_EXEC;
            2'b01:   state_d = S_MEM;
            2'b10:   state_d = S_BRANCH;
            default: begin
              state_d = S_HALT;
              retire  = 1'b1;
            end
          endcase
        end
      end

      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ir_ibit ? 2'd1 : 2'd0;
        ctl.alu_func  = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.z_write   = ir_sbit;
        ctl.n_write   = ir_sbit;
        ctl.v_write   = ir_sbit;
        ctl.c_write   = ir_sbit;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end

      S_MEM: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'd1;
        ctl.iord      = 1'b1;
        if (ir_load) begin
          ctl.mem_read   = 1'b1;
          ctl.reg_write  = dp_if.MemReady;
          ctl.mem_to_reg = dp_if.MemReady ? 2'd1 : 2'd0;
        end else begin
          ctl.reg_in    = 1'b1;
          ctl.mem_write = 1'b1;
        end
        if (dp_if.MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_BRANCH: begin
        // R15 captures the already-incremented PC before this edge loads the target.
        ctl.alu_src_b = 2'd3;
        ctl.pc_write  = 1'b1;
        if (ir_ibit) begin
          ctl.reg_write  = 1'b1;
          ctl.reg_dst    = 1'b1;
          ctl.mem_to_reg = 2'd2;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: halted_int = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // Everything is quiet while rst is high, whatever state the register still holds.
  assign ctl_out = rst ? '0 : ctl;

  assign dp_if.RegDst   = ctl_out.reg_dst;
  assign dp_if.RegIn    = ctl_out.reg_in;
  assign dp_if.RegWrite = ctl_out.reg_write;
  assign dp_if.ALUSrcA  = ctl_out.alu_src_a;
  assign dp_if.ALUFunc  = ctl_out.alu_func;
  assign dp_if.IorD     = ctl_out.iord;
  assign dp_if.PCWrite  = ctl_out.pc_write;
  assign dp_if.IRWrite  = ctl_out.ir_write;
  assign dp_if.ZWrite   = ctl_out.z_write;
  assign dp_if.NWrite   = ctl_out.n_write;
  assign dp_if.VWrite   = ctl_out.v_write;
  assign dp_if.CWrite   = ctl_out.c_write;
  assign dp_if.MemRead  = ctl_out.mem_read;
  assign dp_if.MemWrite = ctl_out.mem_write;
  assign dp_if.ALUSrcB  = ctl_out.alu_src_b;
  assign dp_if.MemtoReg = ctl_out.mem_to_reg;

  assign Halted     = halted_int & ~rst;
  assign RetiredCnt = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class, wait states,
// halt and reset cases against hand-computed control vectors.
module tb_control_unit;

  localparam int CNT_W = 32;

  localparam logic [17:0] C_REGDST   = 18'h20000;
  localparam logic [17:0] C_REGIN    = 18'h10000;
  localparam logic [17:0] C_REGWRITE = 18'h08000;
  localparam logic [17:0] C_SRCA     = 18'h04000;
  localparam logic [17:0] C_FUNC     = 18'h02000;
  localparam logic [17:0] C_IORD     = 18'h01000;
  localparam logic [17:0] C_PCW      = 18'h00800;
  localparam logic [17:0] C_IRW      = 18'h00400;
  localparam logic [17:0] C_FLAGS    = 18'h003C0;
  localparam logic [17:0] C_MRD      = 18'h00020;
  localparam logic [17:0] C_MWR      = 18'h00010;
  localparam logic [17:0] B_SEXT12   = 18'h00004;
  localparam logic [17:0] B_ONE      = 18'h00008;
  localparam logic [17:0] B_SEXT26   = 18'h0000C;
  localparam logic [17:0] M_MEM      = 18'h00001;
  localparam logic [17:0] M_PC       = 18'h00002;

  localparam logic [17:0] V_FETCH_WAIT = C_MRD | B_ONE;
  localparam logic [17:0] V_FETCH_RDY  = C_MRD | B_ONE | C_PCW | C_IRW;
  localparam logic [17:0] V_LOAD_WAIT  = C_SRCA | C_IORD | C_MRD | B_SEXT12;
  localparam logic [17:0] V_LOAD_RDY   = V_LOAD_WAIT | C_REGWRITE | M_MEM;
  localparam logic [17:0] V_STORE      = C_SRCA | C_IORD | C_REGIN | C_MWR | B_SEXT12;

  logic             clk;
  logic             rst;
  logic             Halted;
  logic [CNT_W-1:0] RetiredCnt;
  logic [17:0]      ctl;
  int               n_assert;
  int               n_fail;

  control_unit_if dp_if ();

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .dp_if      (dp_if.master),
    .Halted     (Halted),
    .RetiredCnt (RetiredCnt)
  );

  assign ctl = {dp_if.RegDst, dp_if.RegIn, dp_if.RegWrite, dp_if.ALUSrcA, dp_if.ALUFunc,
                dp_if.IorD, dp_if.PCWrite, dp_if.IRWrite, dp_if.ZWrite, dp_if.NWrite,
                dp_if.VWrite, dp_if.CWrite, dp_if.MemRead, dp_if.MemWrite,
                dp_if.ALUSrcB, dp_if.MemtoReg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then let inputs applied afterwards settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Fetch (ready) then decode with Access=acc, leaving the bench one edge past DECODE.
  task automatic fetch_decode(input string tag, input logic [31:0] ir, input logic acc);
    dp_if.IR = ir; dp_if.MemReady = 1'b1; dp_if.Access = 1'b0;
    settle();
    check({tag, "_fetch"}, 32'(ctl), 32'(V_FETCH_RDY));
    tick();
    dp_if.Access = acc;
    settle();
    check({tag, "_decode"}, 32'(ctl), 32'h0);
    tick();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    dp_if.IR = 32'h0;
    dp_if.Access = 1'b0;
    dp_if.MemReady = 1'b0;

    tick();
    settle();
    check("reset_ctl", 32'(ctl), 32'h0);
    check("reset_halted", 32'(Halted), 32'h0);
    check("reset_cnt", RetiredCnt, 32'd0);
    rst = 1'b0;
    settle();
    check("fetch_stall", 32'(ctl), 32'(V_FETCH_WAIT));

    // Data-proc register op with S=1
    fetch_decode("dp", 32'h00A12003, 1'b1);
    settle();
    check("dp_exec", 32'(ctl), 32'(C_REGWRITE | C_SRCA | C_FUNC | C_FLAGS));
    tick();
    check("dp_cnt", RetiredCnt, 32'd1);

    // Squash
    fetch_decode("sq", 32'h00A12003, 1'b0);
    settle();
    check("sq_back_to_fetch", 32'(ctl), 32'(V_FETCH_RDY));
    check("sq_cnt", RetiredCnt, 32'd2);

    // Load with three wait states
    fetch_decode("ld", 32'h10100000, 1'b1);
    dp_if.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("ld_wait", 32'(ctl), 32'(V_LOAD_WAIT));
      tick();
    end
    check("ld_wait_cnt", RetiredCnt, 32'd2);
    dp_if.MemReady = 1'b1;
    settle();
    check("ld_ready", 32'(ctl), 32'(V_LOAD_RDY));
    tick();
    check("ld_cnt", RetiredCnt, 32'd3);

    // Store with two wait states
    fetch_decode("st", 32'h10000000, 1'b1);
    dp_if.MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("st_wait", 32'(ctl), 32'(V_STORE));
      tick();
    end
    dp_if.MemReady = 1'b1;
    settle();
    check("st_ready", 32'(ctl), 32'(V_STORE));
    tick();
    check("st_cnt", RetiredCnt, 32'd4);

    // Branch with link, then plain branch
    fetch_decode("bl", 32'hA4000005, 1'b1);
    settle();
    check("bl_branch", 32'(ctl), 32'(C_PCW | B_SEXT26 | C_REGWRITE | C_REGDST | M_PC));
    tick();
    check("bl_cnt", RetiredCnt, 32'd5);
    fetch_decode("b", 32'hA0000005, 1'b1);
    settle();
    check("b_branch", 32'(ctl), 32'(C_PCW | B_SEXT26));
    tick();

    // Data-proc immediate, no flag update
    fetch_decode("dpi", 32'h04000000, 1'b1);
    settle();
    check("dpi_exec", 32'(ctl), 32'(C_REGWRITE | C_SRCA | C_FUNC | B_SEXT12));
    tick();
    check("dpi_cnt", RetiredCnt, 32'd7);

    // Halt: counted on entry, silent for 10 cycles
    fetch_decode("hlt", 32'h30000000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      dp_if.MemReady = i[0];
      settle();
      check("hlt_ctl", 32'(ctl), 32'h0);
      check("hlt_halted", 32'(Halted), 32'h1);
      tick();
    end
    check("hlt_cnt", RetiredCnt, 32'd8);
    rst = 1'b1;
    settle();
    check("hlt_rst_ctl", 32'(ctl), 32'h0);
    check("hlt_rst_halted", 32'(Halted), 32'h0);
    tick();
    rst = 1'b0;
    dp_if.MemReady = 1'b1;
    settle();
    check("post_rst_fetch", 32'(ctl), 32'(V_FETCH_RDY));
    check("post_rst_halted", 32'(Halted), 32'h0);
    check("post_rst_cnt", RetiredCnt, 32'd0);

    // Reset during a stalled fetch after one squash retires
    fetch_decode("sq2", 32'h0, 1'b0);
    check("sq2_cnt", RetiredCnt, 32'd1);
    dp_if.MemReady = 1'b0;
    settle();
    check("stall_fetch", 32'(ctl), 32'(V_FETCH_WAIT));
    tick();
    rst = 1'b1;
    settle();
    check("stall_rst_same", 32'(ctl), 32'h0);
    tick();
    check("stall_rst_next", 32'(ctl), 32'h0);
    check("stall_rst_cnt", RetiredCnt, 32'd0);
    rst = 1'b0;
    settle();
    check("restart_fetch", 32'(ctl), 32'(V_FETCH_WAIT));
    dp_if.MemReady = 1'b1;
    settle();
    check("restart_ready", 32'(ctl), 32'(V_FETCH_RDY));
    tick();
    settle();
    check("restart_decode", 32'(ctl), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
